// File: rtl/mitll_merger_clk_if.sv
// Bundle of the merger's pulse-stream signals.
// The master side drives the two toggle-encoded branches. The slave side
// (the merger) returns the merged stream, the coincidence strobe, the sticky
// error flag and the emitted-pulse count.
interface mitll_merger_clk_if #(
    parameter int CNT_W = 8
);
    logic             in1;
    logic             in2;
    logic             out;
    logic             coinc;
    logic             err;
    logic [CNT_W-1:0] pulse_cnt;

    modport master (
        output in1,
        output in2,
        input  out,
        input  coinc,
        input  err,
        input  pulse_cnt
    );

    modport slave (
        input  in1,
        input  in2,
        output out,
        output coinc,
        output err,
        output pulse_cnt
    );
endinterface

// File: rtl/mitll_merger_clk.sv
// Clocked confluence (merger) cell for toggle-encoded SFQ pulse streams.
// A level change on in1 or in2 is one pulse. Accepted pulses are delayed by
// DELAY edges and then re-emitted as a toggle on out. A pulse that arrives
// inside the hold-off window after an accepted pulse is a timing violation.
// A violation latches err, drops everything still in flight, and freezes the
// cell until rst. Pulses arriving during the post-reset settling period are
// ignored.
//
// DELAY must be in 1..16. HOLDOFF = 0 turns off the hold-off check, so
// back-to-back pulses are then legal.
module mitll_merger_clk #(
    parameter int DELAY   = 3,
    parameter int HOLDOFF = 2,
    parameter int WARMUP  = 4,
    parameter int CNT_W   = 8
) (
    input  logic              clk,
    input  logic              rst,
    mitll_merger_clk_if.slave bus
);

    // Counter widths, never narrower than one bit.
    localparam int HW = (HOLDOFF > 1) ? $clog2(HOLDOFF + 1) : 1;
    localparam int WW = (WARMUP > 1) ? $clog2(WARMUP + 1) : 1;

    localparam logic [HW-1:0]    HOLD_LOAD = HW'(HOLDOFF);
    localparam logic [HW-1:0]    HOLD_ONE  = HW'(1);
    localparam logic [WW-1:0]    WARM_LOAD = WW'(WARMUP);
    localparam logic [WW-1:0]    WARM_ONE  = WW'(1);
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        ST_WARMUP = 2'd0,
        ST_IDLE   = 2'd1,
        ST_HOLD   = 2'd2,
        ST_ERR    = 2'd3
    } state_t;

    state_t           state_reg;
    logic [WW-1:0]    warm_cnt_reg;
    logic [HW-1:0]    hold_cnt_reg;
    logic             in1_q_reg;
    logic             in2_q_reg;
    logic             out_reg;
    logic             coinc_reg;
    logic             err_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [DELAY-1:0] pipe_reg;
    logic [DELAY-1:0] pipe_next;

    logic p1;
    logic p2;
    logic pulse;
    logic push;
    logic violation;
    logic flush;
    logic emit;

    // Edge detection against the level seen at the previous edge.
    assign p1    = bus.in1 ^ in1_q_reg;
    assign p2    = bus.in2 ^ in2_q_reg;
    assign pulse = p1 | p2;

    // Only IDLE accepts pulses. Any pulse inside the hold-off window is a
    // violation.
    assign push      = (state_reg == ST_IDLE) && pulse;
    assign violation = (state_reg == ST_HOLD) && pulse;

    // The violating edge itself already discards in-flight pulses, so nothing
    // accepted before the violation can still reach out.
    assign flush = (state_reg == ST_ERR) || violation;

    // A pulse leaving the end of the delay line toggles out. This is blocked
    // from the violating edge onward, so out holds the level it had when the
    // error occurred.
    assign emit = pipe_reg[DELAY-1] && (state_reg != ST_ERR) && !violation;

    // Delay line next-state. The head takes newly accepted events and every
    // later stage takes the stage before it. A flush zeroes the whole line.
    generate
        genvar gi;
        for (gi = 0; gi < DELAY; gi++) begin : g_pipe
            if (gi == 0) begin : g_head
                assign pipe_next[gi] = push & ~flush;
            end else begin : g_stage
                assign pipe_next[gi] = pipe_reg[gi-1] & ~flush;
            end
        end
    endgenerate

    // Delay line register. Reset discards all pulses that are still pending.
    always_ff @(posedge clk) begin
        if (rst) begin
            pipe_reg <= '0;
        end else begin
            pipe_reg <= pipe_next;
        end
    end

    // Input history register. It tracks the input levels at every edge,
    // including reset, so that a static level held through reset never looks
    // like a pulse.
    always_ff @(posedge clk) begin
        in1_q_reg <= bus.in1;
        in2_q_reg <= bus.in2;
    end

    // Control FSM plus all registered outputs: warmup, accept, hold-off
    // window, error lock, output toggle and saturating pulse count.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= ST_WARMUP;
            warm_cnt_reg <= WARM_LOAD;
            hold_cnt_reg <= HOLD_LOAD;
            out_reg      <= 1'b0;
            coinc_reg    <= 1'b0;
            err_reg      <= 1'b0;
            cnt_reg      <= '0;
        end else begin
            coinc_reg <= 1'b0;

            if (emit) begin
                out_reg <= ~out_reg;
                if (cnt_reg != CNT_MAX) begin
                    cnt_reg <= cnt_reg + 1'b1;
                end
            end

            unique case (state_reg)
                ST_WARMUP: begin
                    // A settling length of zero still spends the first edge
                    // here, then moves on.
                    if (warm_cnt_reg <= WARM_ONE) begin
                        state_reg <= ST_IDLE;
                    end else begin
                        warm_cnt_reg <= warm_cnt_reg - WARM_ONE;
                    end
                end

                ST_IDLE: begin
                    if (pulse) begin
                        // Simultaneous pulses merge into one event.
                        coinc_reg <= p1 & p2;
                        if (HOLDOFF > 0) begin
                            state_reg    <= ST_HOLD;
                            hold_cnt_reg <= HOLD_LOAD;
                        end
                    end
                end

                ST_HOLD: begin
                    // The window includes the edge on which the counter
                    // reaches zero, so a pulse on that edge is still an error.
                    if (pulse) begin
                        state_reg <= ST_ERR;
                        err_reg   <= 1'b1;
                    end else begin
                        hold_cnt_reg <= hold_cnt_reg - HOLD_ONE;
                        if (hold_cnt_reg == HOLD_ONE) begin
                            state_reg <= ST_IDLE;
                        end
                    end
                end

                ST_ERR: begin
                    err_reg <= 1'b1;
                end
            endcase
        end
    end

    assign bus.out       = out_reg;
    assign bus.coinc     = coinc_reg;
    assign bus.err       = err_reg;
    assign bus.pulse_cnt = cnt_reg;

endmodule

// File: tb/tb_mitll_merger_clk.sv
// Bench for mitll_merger_clk. Two instances run in lockstep:
//   - A uses the default parameters.
//   - B uses a short delay, no hold-off, no settling time and a 2-bit count.
// For every edge, the driver advances a behavioural model and pushes the
// expected outputs into per-instance queues, tagged with the edge number.
// A separate monitor runs just after each rising edge and compares the DUT
// outputs with those queues.
module tb_mitll_merger_clk;

    localparam int A_DELAY = 3, A_HOLD = 2, A_WARM = 4, A_CW = 8;
    localparam int B_DELAY = 2, B_HOLD = 0, B_WARM = 0, B_CW = 2;

    logic        clk = 1'b0;
    logic        rst_v   [2];
    logic        lvl1    [2];
    logic        lvl2    [2];
    logic        out_v   [2];
    logic        coinc_v [2];
    logic        err_v   [2];
    logic [31:0] cnt_v   [2];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    mitll_merger_clk_if #(.CNT_W(A_CW)) bus_a ();
    mitll_merger_clk_if #(.CNT_W(B_CW)) bus_b ();

    assign bus_a.in1  = lvl1[0];
    assign bus_a.in2  = lvl2[0];
    assign bus_b.in1  = lvl1[1];
    assign bus_b.in2  = lvl2[1];

    assign out_v[0]   = bus_a.out;
    assign coinc_v[0] = bus_a.coinc;
    assign err_v[0]   = bus_a.err;
    assign cnt_v[0]   = 32'(bus_a.pulse_cnt);

    assign out_v[1]   = bus_b.out;
    assign coinc_v[1] = bus_b.coinc;
    assign err_v[1]   = bus_b.err;
    assign cnt_v[1]   = 32'(bus_b.pulse_cnt);

    mitll_merger_clk #(
        .DELAY(A_DELAY), .HOLDOFF(A_HOLD), .WARMUP(A_WARM), .CNT_W(A_CW)
    ) dut_a (
        .clk(clk), .rst(rst_v[0]), .bus(bus_a)
    );

    mitll_merger_clk #(
        .DELAY(B_DELAY), .HOLDOFF(B_HOLD), .WARMUP(B_WARM), .CNT_W(B_CW)
    ) dut_b (
        .clk(clk), .rst(rst_v[1]), .bus(bus_b)
    );

    // ---------------- per-instance parameters ----------------
    function automatic int p_delay(int d);
        return (d == 0) ? A_DELAY : B_DELAY;
    endfunction

    function automatic int p_hold(int d);
        return (d == 0) ? A_HOLD : B_HOLD;
    endfunction

    // Number of edges after reset release on which input pulses are ignored.
    function automatic int p_warm_len(int d);
        int w;
        w = (d == 0) ? A_WARM : B_WARM;
        return (w == 0) ? 1 : w;
    endfunction

    function automatic int p_cmax(int d);
        return (d == 0) ? ((1 << A_CW) - 1) : ((1 << B_CW) - 1);
    endfunction

    // ---------------- scoreboard queues ----------------
    typedef struct {
        int e;
        int c;
        bit o;
    } emit_t;

    emit_t emit_q  [2][$];
    int    coinc_q [2][$];
    int    err_q   [2][$];

    // ---------------- behavioural model ----------------
    int m_edge     [2];
    int m_hold_end [2];
    int m_cnt      [2];
    bit m_out      [2];
    bit m_err      [2];
    bit m_prev1    [2];
    bit m_prev2    [2];
    int m_pend     [2][$];

    task automatic model_reset(int d);
        m_edge[d]     = 0;
        m_hold_end[d] = 0;
        m_cnt[d]      = 0;
        m_out[d]      = 1'b0;
        m_err[d]      = 1'b0;
        m_prev1[d]    = lvl1[d];
        m_prev2[d]    = lvl2[d];
        m_pend[d].delete();
    endtask

    // Advance the model by one non-reset edge, using the input levels that
    // are about to be sampled.
    task automatic model_step(int d);
        int    e;
        bit    p1;
        bit    p2;
        emit_t r;
        m_edge[d]++;
        e  = m_edge[d];
        p1 = (lvl1[d] != m_prev1[d]);
        p2 = (lvl2[d] != m_prev2[d]);
        m_prev1[d] = lvl1[d];
        m_prev2[d] = lvl2[d];
        if (m_err[d]) return;
        if (e <= p_warm_len(d)) begin
            // settling period: pulses ignored
        end else if (e <= m_hold_end[d]) begin
            if (p1 || p2) begin
                m_err[d] = 1'b1;
                m_pend[d].delete();
                err_q[d].push_back(e);
                return;
            end
        end else if (p1 || p2) begin
            m_pend[d].push_back(e + p_delay(d));
            if (p1 && p2) coinc_q[d].push_back(e);
            m_hold_end[d] = e + p_hold(d);
        end
        if (m_pend[d].size() > 0 && m_pend[d][0] == e) begin
            void'(m_pend[d].pop_front());
            m_out[d] = !m_out[d];
            if (m_cnt[d] < p_cmax(d)) m_cnt[d]++;
            r.e = e;
            r.c = m_cnt[d];
            r.o = m_out[d];
            emit_q[d].push_back(r);
        end
    endtask

    // ---------------- monitor ----------------
    int mon_edge [2];
    bit mon_out  [2];
    bit mon_err  [2];
    int mon_cnt  [2];

    task automatic chk(string name, int d, int act, int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s dut%0d edge %0d: got %0d, expected %0d",
                     name, d, mon_edge[d], act, exp);
        end
    endtask

    task automatic mon_step(int d);
        emit_t r;
        bit    exp_c;
        if (rst_v[d]) begin
            chk("rst_out",   d, int'(out_v[d]),   0);
            chk("rst_coinc", d, int'(coinc_v[d]), 0);
            chk("rst_err",   d, int'(err_v[d]),   0);
            chk("rst_cnt",   d, int'(cnt_v[d]),   0);
            mon_edge[d] = 0;
            mon_out[d]  = 1'b0;
            mon_err[d]  = 1'b0;
            mon_cnt[d]  = 0;
            return;
        end
        mon_edge[d]++;
        if (emit_q[d].size() > 0 && emit_q[d][0].e == mon_edge[d]) begin
            r = emit_q[d].pop_front();
            chk("out_toggle", d, int'(out_v[d]), int'(r.o));
            chk("out_cnt",    d, int'(cnt_v[d]), r.c);
            mon_out[d] = r.o;
            mon_cnt[d] = r.c;
            $display("[TB] dut%0d edge %0d pulse out=%0b cnt=%0d",
                     d, mon_edge[d], out_v[d], cnt_v[d]);
        end else begin
            chk("out_steady", d, int'(out_v[d]), int'(mon_out[d]));
            chk("cnt_steady", d, int'(cnt_v[d]), mon_cnt[d]);
        end
        exp_c = (coinc_q[d].size() > 0 && coinc_q[d][0] == mon_edge[d]);
        if (exp_c) begin
            void'(coinc_q[d].pop_front());
            $display("[TB] dut%0d edge %0d coincidence coinc=%0b",
                     d, mon_edge[d], coinc_v[d]);
        end
        chk("coinc", d, int'(coinc_v[d]), int'(exp_c));
        if (err_q[d].size() > 0 && err_q[d][0] == mon_edge[d]) begin
            void'(err_q[d].pop_front());
            mon_err[d] = 1'b1;
            $display("[TB] dut%0d edge %0d violation err=%0b",
                     d, mon_edge[d], err_v[d]);
        end
        chk("err", d, int'(err_v[d]), int'(mon_err[d]));
    endtask

    always @(posedge clk) begin
        #1;
        for (int d = 0; d < 2; d++) mon_step(d);
    end

    // ---------------- driver ----------------
    // For a reset edge, the mask gives the input levels; otherwise it gives
    // the toggles (bit0 = in1, bit1 = in2).
    task automatic step(int d, bit r, bit [1:0] m);
        if (r) begin
            rst_v[d] = 1'b1;
            lvl1[d]  = m[0];
            lvl2[d]  = m[1];
            model_reset(d);
        end else begin
            rst_v[d] = 1'b0;
            lvl1[d]  = lvl1[d] ^ m[0];
            lvl2[d]  = lvl2[d] ^ m[1];
            model_step(d);
        end
    endtask

    task automatic tick(bit r, bit [1:0] m0, bit [1:0] m1);
        @(negedge clk);
        step(0, r, m0);
        step(1, r, m1);
    endtask

    task automatic reset_edges(int n, bit [1:0] levels);
        for (int i = 0; i < n; i++) tick(1'b1, levels, levels);
    endtask

    // Both instances receive the same scripted toggles: mask ma at edge ea,
    // mask mb at edge eb.
    task automatic directed(int len, int ea, bit [1:0] ma, int eb, bit [1:0] mb);
        bit [1:0] m;
        for (int e = 1; e <= len; e++) begin
            m = 2'b00;
            if (e == ea) m = m | ma;
            if (e == eb) m = m | mb;
            tick(1'b0, m, m);
        end
    endtask

    task automatic periodic(int len, int start, int period);
        bit [1:0] m;
        for (int e = 1; e <= len; e++) begin
            m = (e >= start && ((e - start) % period) == 0) ? 2'b01 : 2'b00;
            tick(1'b0, m, m);
        end
    endtask

    task automatic random_phase(int len, int rate0, int rate1);
        bit [1:0] m0;
        bit [1:0] m1;
        for (int e = 1; e <= len; e++) begin
            m0[0] = ($urandom_range(99) < rate0);
            m0[1] = ($urandom_range(99) < rate0);
            m1[0] = ($urandom_range(99) < rate1);
            m1[1] = ($urandom_range(99) < rate1);
            tick(1'b0, m0, m1);
        end
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            rst_v[d] = 1'b1;
            lvl1[d]  = 1'b0;
            lvl2[d]  = 1'b0;
            model_reset(d);
        end

        // Static level held through reset, then no activity.
        reset_edges(2, 2'b01);
        directed(30, 0, 2'b00, 0, 2'b00);
        // Pulse on in1 at edge 10, then on in2 at edge 20.
        reset_edges(2, 2'b00);
        directed(30, 10, 2'b01, 20, 2'b10);
        // Coincident pulses on both inputs.
        reset_edges(1, 2'b00);
        directed(20, 10, 2'b11, 0, 2'b00);
        // Second pulse inside the hold-off window.
        reset_edges(1, 2'b00);
        directed(20, 10, 2'b01, 12, 2'b10);
        // Second pulse just after the window closes.
        reset_edges(1, 2'b00);
        directed(20, 10, 2'b01, 13, 2'b10);
        // Pulse during settling, then reset while a pulse is in flight.
        reset_edges(1, 2'b00);
        directed(10, 2, 2'b01, 10, 2'b01);
        reset_edges(1, 2'b00);
        directed(20, 0, 2'b00, 0, 2'b00);
        // Five spaced pulses, which saturate the 2-bit counter of instance B.
        reset_edges(1, 2'b00);
        periodic(34, 5, 6);

        // Randomized phases. Each phase starts with a reset, which also cuts
        // off whatever the previous phase still had in flight.
        for (int ph = 0; ph < 24; ph++) begin
            reset_edges(int'($urandom_range(1, 2)), 2'($urandom_range(3)));
            random_phase(int'($urandom_range(30, 80)),
                         int'($urandom_range(2, 30)),
                         int'($urandom_range(2, 45)));
        end

        directed(8, 0, 2'b00, 0, 2'b00);
        @(posedge clk);
        #2;
        for (int d = 0; d < 2; d++) begin
            chk("drain_emit",  d, emit_q[d].size(),  0);
            chk("drain_coinc", d, coinc_q[d].size(), 0);
            chk("drain_err",   d, err_q[d].size(),   0);
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
